// File: rtl/life_next_state_engine_if.sv
// Bus between the Game of Life scan/rule engine and its neighbour-fetch stage,
// next-screen buffer and control. LIFE_RULE_PROG_EN adds the rule mask inputs.
interface life_next_state_engine_if #(
  parameter int unsigned X_W   = 7,
  parameter int unsigned Y_W   = 6,
  parameter int unsigned CNT_W = 13,
  parameter int unsigned GEN_W = 16
);
  logic             start;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic             cell_in;
  logic [3:0]       sum_neighbours;
  logic             next_we;
  logic [X_W-1:0]   next_x;
  logic [Y_W-1:0]   next_y;
  logic             next_cell;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] live_count;
  logic [GEN_W-1:0] generation;
`ifdef LIFE_RULE_PROG_EN
  logic [8:0]       birth_mask;
  logic [8:0]       survive_mask;

  modport master (
    input  start, cell_in, sum_neighbours, birth_mask, survive_mask,
    output x, y, next_we, next_x, next_y, next_cell, busy, done, live_count, generation
  );
  modport slave (
    output start, cell_in, sum_neighbours, birth_mask, survive_mask,
    input  x, y, next_we, next_x, next_y, next_cell, busy, done, live_count, generation
  );
`else
  modport master (
    input  start, cell_in, sum_neighbours,
    output x, y, next_we, next_x, next_y, next_cell, busy, done, live_count, generation
  );
  modport slave (
    output start, cell_in, sum_neighbours,
    input  x, y, next_we, next_x, next_y, next_cell, busy, done, live_count, generation
  );
`endif
endinterface

// File: rtl/life_next_state_engine.sv
// Raster-scans one Game of Life generation, applies the life rule to the registered
// neighbour sum and writes the next screen. LIFE_RULE_PROG_EN enables programmable B/S masks.
module life_next_state_engine #(
  parameter int unsigned MAX_i = 79,
  parameter int unsigned MAX_j = 59,
  parameter int unsigned X_W   = 7,
  parameter int unsigned Y_W   = 6,
  parameter int unsigned CNT_W = 13,
  parameter int unsigned GEN_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  life_next_state_engine_if.master bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [X_W-1:0] LP_MAX_X = X_W'(MAX_i);
  localparam logic [Y_W-1:0] LP_MAX_Y = Y_W'(MAX_j);

  logic [1:0]       r_state;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [X_W-1:0]   r_next_x;
  logic [Y_W-1:0]   r_next_y;
  logic             r_we;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_live_count;
  logic [GEN_W-1:0] r_generation;
  logic             w_rule;
  logic             w_next_cell;
  logic [CNT_W-1:0] w_count_next;

`ifdef LIFE_RULE_PROG_EN
  logic [8:0] r_birth;
  logic [8:0] r_survive;

  always_comb begin
    w_rule = 1'b0;
    if (bus.sum_neighbours <= 4'd8)
      w_rule = bus.cell_in ? r_survive[bus.sum_neighbours] : r_birth[bus.sum_neighbours];
  end
`else
  always_comb begin
    w_rule = (bus.sum_neighbours == 4'd3) | (bus.cell_in & (bus.sum_neighbours == 4'd2));
  end
`endif

  // cell_in/sum_neighbours arrive in the same cycle as the registered write strobe
  assign w_next_cell  = r_we & w_rule;
  assign w_count_next = r_count + CNT_W'(w_next_cell);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_next_x     <= '0;
      r_next_y     <= '0;
      r_we         <= 1'b0;
      r_count      <= '0;
      r_live_count <= '0;
      r_generation <= '0;
`ifdef LIFE_RULE_PROG_EN
      r_birth      <= '0;
      r_survive    <= '0;
`endif
    end else begin
      r_we     <= (r_state == S_SCAN);
      r_next_x <= r_x;
      r_next_y <= r_y;
      if (r_we)
        r_count <= w_count_next;

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_x     <= '0;
            r_y     <= '0;
            r_count <= '0;
            r_state <= S_SCAN;
`ifdef LIFE_RULE_PROG_EN
            r_birth   <= bus.birth_mask;
            r_survive <= bus.survive_mask;
`endif
          end
        end
        S_SCAN: begin
          if (r_x == LP_MAX_X) begin
            if (r_y == LP_MAX_Y) begin
              r_state <= S_DRAIN;
            end else begin
              r_x <= '0;
              r_y <= r_y + Y_W'(1);
            end
          end else begin
            r_x <= r_x + X_W'(1);
          end
        end
        // last write is in flight here; fold it into the published count
        S_DRAIN: begin
          r_live_count <= w_count_next;
          r_generation <= r_generation + GEN_W'(1);
          r_state      <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.x          = r_x;
  assign bus.y          = r_y;
  assign bus.next_we    = r_we;
  assign bus.next_x     = r_next_x;
  assign bus.next_y     = r_next_y;
  assign bus.next_cell  = w_next_cell;
  assign bus.busy       = (r_state == S_SCAN) || (r_state == S_DRAIN);
  assign bus.done       = (r_state == S_DONE);
  assign bus.live_count = r_live_count;
  assign bus.generation = r_generation;

endmodule

// File: tb/tb_life_next_state_engine.sv
// Bench for life_next_state_engine on a 5x5 screen: stubbed neighbour stage over a
// screen model, expected next generation computed from the life rule per cell.
module tb_life_next_state_engine;
  localparam int N     = 5;
  localparam int CELLS = N * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  life_next_state_engine_if #(.X_W(3), .Y_W(3), .CNT_W(5), .GEN_W(16)) bus ();

  life_next_state_engine #(
    .MAX_i(4), .MAX_j(4), .X_W(3), .Y_W(3), .CNT_W(5), .GEN_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  bit         cur     [N][N];
  bit         exp_nxt [N][N];
  bit         force_mode = 1'b0;
  bit         scramble   = 1'b0;
  bit         fcell [CELLS];
  logic [3:0] fsum  [CELLS];
  logic [8:0] m_birth   = 9'b000001000;
  logic [8:0] m_survive = 9'b000001100;
  int         exp_gen  = 0;
  int         exp_live = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int nsum(input int xi, input int yi);
    int s = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if ((dx != 0 || dy != 0) && xi + dx >= 0 && xi + dx < N && yi + dy >= 0 && yi + dy < N)
          s += int'(cur[yi+dy][xi+dx]);
    return s;
  endfunction

  function automatic bit rule_ref(input bit c, input int s);
    if (s > 8) return 1'b0;
    return c ? m_survive[s] : m_birth[s];
  endfunction

  // Neighbour-fetch stub: one-cycle registered lookup of the screen model
  always @(posedge clk) begin
    int xi, yi;
    xi = int'(bus.x);
    yi = int'(bus.y);
    if (force_mode) begin
      bus.cell_in        <= fcell[yi*N+xi];
      bus.sum_neighbours <= fsum[yi*N+xi];
    end else begin
      bus.cell_in        <= cur[yi][xi];
      bus.sum_neighbours <= 4'(nsum(xi, yi));
    end
  end

  task automatic build_expect();
    bit c;
    int s;
    exp_live = 0;
    for (int yy = 0; yy < N; yy++)
      for (int xx = 0; xx < N; xx++) begin
        c = force_mode ? fcell[yy*N+xx] : cur[yy][xx];
        s = force_mode ? int'(fsum[yy*N+xx]) : nsum(xx, yy);
        exp_nxt[yy][xx] = rule_ref(c, s);
        exp_live += int'(exp_nxt[yy][xx]);
      end
  endtask

  task automatic advance_screen();
    for (int yy = 0; yy < N; yy++)
      for (int xx = 0; xx < N; xx++)
        cur[yy][xx] = exp_nxt[yy][xx];
  endtask

  task automatic run_gen(input string name, input int pulse_at, input int rst_at, input bit hold);
    int nw = 0, nbusy = 0, first_we = -1, last_we = -1, done_at = -1;
    logic [2:0] px = '0, py = '0;
    build_expect();
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!hold) bus.start = (c == pulse_at);
`ifdef LIFE_RULE_PROG_EN
      if (scramble && c == 5) begin
        bus.birth_mask   = ~m_birth;
        bus.survive_mask = ~m_survive;
      end
`endif
      if (bus.busy) nbusy++;
      if (bus.next_we) begin
        if (first_we < 0) first_we = c;
        last_we = c;
        if (nw < CELLS) begin
          check_eq({name, ":wr_x"}, 32'(bus.next_x), nw % N);
          check_eq({name, ":wr_y"}, 32'(bus.next_y), nw / N);
          check_eq({name, ":wr_cell"}, 32'(bus.next_cell), 32'(exp_nxt[nw/N][nw%N]));
        end
        check_eq({name, ":wr_follows_issue"}, {26'd0, bus.next_y, bus.next_x}, {26'd0, py, px});
        nw++;
      end else begin
        check_eq({name, ":cell_outside_write"}, 32'(bus.next_cell), 0);
      end
      px = bus.x;
      py = bus.y;
      if (rst_at > 0 && nw == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        check_eq({name, ":rst_busy"}, 32'(bus.busy), 0);
        check_eq({name, ":rst_we"}, 32'(bus.next_we), 0);
        check_eq({name, ":rst_gen"}, 32'(bus.generation), 0);
        check_eq({name, ":rst_live"}, 32'(bus.live_count), 0);
        repeat (3) begin
          @(negedge clk);
          check_eq({name, ":rst_no_done"}, 32'(bus.done), 0);
          check_eq({name, ":rst_no_we"}, 32'(bus.next_we), 0);
        end
        rst = 1'b0;
        exp_gen = 0;
        return;
      end
      if (bus.done) begin
        done_at = c;
        break;
      end
    end
    exp_gen++;
    check_eq({name, ":done_cycle"}, done_at, 26);
    check_eq({name, ":busy_cycles"}, nbusy, 26);
    check_eq({name, ":first_write"}, first_we, 1);
    check_eq({name, ":last_write"}, last_we, 25);
    check_eq({name, ":writes"}, nw, CELLS);
    check_eq({name, ":busy_at_done"}, 32'(bus.busy), 0);
    check_eq({name, ":live_count"}, 32'(bus.live_count), exp_live);
    check_eq({name, ":generation"}, 32'(bus.generation), exp_gen);
    @(negedge clk);
    check_eq({name, ":done_one_cycle"}, 32'(bus.done), 0);
    check_eq({name, ":idle_busy"}, 32'(bus.busy), 0);
    if (hold) begin
      @(negedge clk);
      check_eq({name, ":restart_busy"}, 32'(bus.busy), 1);
      check_eq({name, ":restart_xy"}, {26'd0, bus.y, bus.x}, 0);
      bus.start = 1'b0;
      done_at = -1;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (bus.done) begin
          done_at = c;
          break;
        end
      end
      exp_gen++;
      check_eq({name, ":second_done"}, 32'(done_at >= 0), 1);
      check_eq({name, ":second_live"}, 32'(bus.live_count), exp_live);
      check_eq({name, ":second_gen"}, 32'(bus.generation), exp_gen);
      @(negedge clk);
    end
  endtask

  task automatic clear_screen();
    for (int yy = 0; yy < N; yy++)
      for (int xx = 0; xx < N; xx++)
        cur[yy][xx] = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_gen = 0;
  endtask

  initial begin
    bus.start = 1'b0;
`ifdef LIFE_RULE_PROG_EN
    bus.birth_mask   = m_birth;
    bus.survive_mask = m_survive;
`endif
    repeat (3) @(negedge clk);
    check_eq("reset:busy", 32'(bus.busy), 0);
    check_eq("reset:done", 32'(bus.done), 0);
    check_eq("reset:we", 32'(bus.next_we), 0);
    check_eq("reset:cell", 32'(bus.next_cell), 0);
    check_eq("reset:xy", {26'd0, bus.y, bus.x}, 0);
    check_eq("reset:next_xy", {26'd0, bus.next_y, bus.next_x}, 0);
    check_eq("reset:live", 32'(bus.live_count), 0);
    check_eq("reset:gen", 32'(bus.generation), 0);
    rst = 1'b0;

    clear_screen();
    run_gen("dead", -1, 0, 1'b0);

    pulse_reset();
    clear_screen();
    cur[2][1] = 1'b1; cur[2][2] = 1'b1; cur[2][3] = 1'b1;
    run_gen("blink1", -1, 0, 1'b0);
    check_eq("blink1:vertical", {29'd0, exp_nxt[1][2], exp_nxt[2][2], exp_nxt[3][2]}, 7);
    advance_screen();
    run_gen("blink2", -1, 0, 1'b0);
    check_eq("blink2:horizontal", {29'd0, exp_nxt[2][1], exp_nxt[2][2], exp_nxt[2][3]}, 7);
    advance_screen();

    for (int i = 0; i < CELLS; i++) begin
      if (i < 18) begin
        fcell[i] = (i >= 9);
        fsum[i]  = 4'(i % 9);
      end else begin
        fcell[i] = 1'($urandom_range(0, 1));
        fsum[i]  = 4'(9 + i - 18);
      end
    end
    force_mode = 1'b1;
    run_gen("rules", -1, 0, 1'b0);
    force_mode = 1'b0;

    for (int g = 0; g < 3; g++) begin
      for (int yy = 0; yy < N; yy++)
        for (int xx = 0; xx < N; xx++)
          cur[yy][xx] = 1'($urandom_range(0, 1));
      run_gen("random", -1, 0, 1'b0);
    end

    run_gen("start_in_scan", 5, 0, 1'b0);
    run_gen("start_held", -1, 0, 1'b1);

    clear_screen();
    cur[2][1] = 1'b1; cur[2][2] = 1'b1; cur[2][3] = 1'b1;
    run_gen("pre_rst", -1, 0, 1'b0);
    run_gen("rst_mid", -1, 10, 1'b0);

`ifdef LIFE_RULE_PROG_EN
    for (int i = 0; i < CELLS; i++) begin
      fcell[i] = 1'($urandom_range(0, 1));
      fsum[i]  = 4'($urandom_range(0, 8));
    end
    fcell[7] = 1'b0;
    fsum[7]  = 4'd6;
    m_birth   = 9'b001001000;
    m_survive = 9'b000001100;
    bus.birth_mask   = m_birth;
    bus.survive_mask = m_survive;
    force_mode = 1'b1;
    scramble   = 1'b1;
    run_gen("highlife", -1, 0, 1'b0);
    check_eq("highlife:b6_expected", 32'(exp_nxt[1][2]), 1);
    scramble  = 1'b0;
    m_birth   = bus.birth_mask;
    m_survive = bus.survive_mask;
    run_gen("new_masks", -1, 0, 1'b0);
    force_mode = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
